// File: rtl/l2_mp_trace_pkg.sv
// Package: l2_mp_trace_pkg
// Shared types and default parameters for the L2 main-pipe trace buffer.
//   - DEF_*        : default parameter values used by l2_mp_trace_buffer
//   - trace_rec_t  : one buffered entry, {stamp, payload}
//   - l2_mp_rec_t  : field layout of the 64-bit main-pipe debug record
//   - pack_mp_rec  : flattens an l2_mp_rec_t into a payload word
package l2_mp_trace_pkg;

    localparam int unsigned DEF_NUM_CH  = 2;
    localparam int unsigned DEF_REC_W   = 64;
    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_STAMP_W = 64;
    localparam int unsigned DEF_DROP_W  = 16;

    typedef struct packed {
        logic [DEF_STAMP_W-1:0] stamp;
        logic [DEF_REC_W-1:0]   payload;
    } trace_rec_t;

    // Main-pipe record layout, MSB first; totals DEF_REC_W bits.
    typedef struct packed {
        logic [31:0] tag;
        logic [11:0] sset;
        logic [3:0]  meta_wway;
        logic [3:0]  opcode;
        logic [2:0]  channel;
        logic [8:0]  misc;
    } l2_mp_rec_t;

    function automatic logic [DEF_REC_W-1:0] pack_mp_rec(input l2_mp_rec_t rec);
        return rec;
    endfunction

endpackage

// File: rtl/l2_mp_trace_buffer_chan_fifo.sv
// Module: trace_chan_fifo
// Single-clock 1W1R FIFO holding one trace channel's entries.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset (empties FIFO)
//   push, wdata   : write strobe and entry; caller must not push when full
//                   unless popping in the same cycle
//   pop           : read strobe; caller must not pop when empty
//   rdata         : head entry (valid while !empty)
//   level         : occupancy, DEPTH when full
//   full, empty   : occupancy flags
module trace_chan_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 128,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign level = count;
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/l2_mp_trace_buffer.sv
// Module: l2_mp_trace_buffer
// Multi-channel trace capture: each channel pushes a record that is stamped
// and queued in its own FIFO; a round-robin drain presents one record per
// cycle on a valid/ready port. Pushes to a full channel are dropped and
// counted so the source pipeline never stalls.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   freeze              : 1 ignores all pushes (not counted); drain continues
//   stamp               : cycle stamp captured with each accepted push
//   in_valid, in_data   : per-channel push strobe, channel c at [c*REC_W +: REC_W]
//   out_valid/out_ready : drain handshake
//   out_ch, out_data,
//   out_stamp           : presented record, its channel and capture stamp
//   drop_cnt            : per-channel saturating drop counters
//   level               : per-channel FIFO occupancy
module l2_mp_trace_buffer
    import l2_mp_trace_pkg::*;
#(
    parameter  int unsigned NUM_CH  = DEF_NUM_CH,
    parameter  int unsigned REC_W   = DEF_REC_W,
    parameter  int unsigned DEPTH   = DEF_DEPTH,
    parameter  int unsigned STAMP_W = DEF_STAMP_W,
    parameter  int unsigned DROP_W  = DEF_DROP_W,
    localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LW      = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     freeze,
    input  logic [STAMP_W-1:0]       stamp,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*REC_W-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_ch,
    output logic [REC_W-1:0]         out_data,
    output logic [STAMP_W-1:0]       out_stamp,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt,
    output logic [NUM_CH*LW-1:0]     level
);

    localparam int unsigned ENT_W = STAMP_W + REC_W;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [ENT_W-1:0]  head [NUM_CH];

    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] rr_next;
    logic [CW-1:0] grant;
    logic [CW-1:0] lock_ch;
    logic          lock;
    logic          accept;
    int unsigned   arb_idx;

    assign out_valid = |(~empty);
    assign accept    = out_valid && out_ready;

    // Scan from the farthest offset down to rr_ptr so the nearest
    // non-empty channel at or after rr_ptr is the last one written.
    always_comb begin
        grant   = rr_ptr;
        arb_idx = 0;
        if (lock) begin
            grant = lock_ch;
        end else begin
            for (int unsigned i = NUM_CH; i > 0; i--) begin
                arb_idx = 32'(rr_ptr) + (i - 1);
                if (arb_idx >= NUM_CH) begin
                    arb_idx = arb_idx - NUM_CH;
                end
                if (!empty[CW'(arb_idx)]) begin
                    grant = CW'(arb_idx);
                end
            end
        end
    end

    always_comb begin
        if (NUM_CH == 1 || grant == CW'(NUM_CH - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant + CW'(1);
        end
    end

    // A presented record that is not accepted pins the grant until the
    // accepting cycle, so the output stays stable while others fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
            lock   <= 1'b0;
        end else if (out_valid) begin
            lock    <= 1'b1;
            lock_ch <= grant;
        end
    end

    assign out_ch    = grant;
    assign out_data  = head[grant][REC_W-1:0];
    assign out_stamp = head[grant][ENT_W-1 -: STAMP_W];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DROP_W-1:0] drops;

        assign pop[c]  = accept && (grant == CW'(c));
        // A full channel that is popping this cycle still has room.
        assign push[c] = in_valid[c] && !freeze && (!full[c] || pop[c]);
        assign drop[c] = in_valid[c] && !freeze && full[c] && !pop[c];

        trace_chan_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata ({stamp, in_data[c*REC_W +: REC_W]}),
            .rdata (head[c]),
            .level (level[c*LW +: LW]),
            .full  (full[c]),
            .empty (empty[c])
        );

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                drops <= '0;
            end else if (drop[c] && drops != '1) begin
                drops <= drops + DROP_W'(1);
            end
        end

        assign drop_cnt[c*DROP_W +: DROP_W] = drops;
    end

endmodule

// File: tb/tb_l2_mp_trace_buffer.sv
// Testbench: tb_l2_mp_trace_buffer
// Directed vectors with hand-computed expectations for l2_mp_trace_buffer
// (NUM_CH=2, REC_W=64, DEPTH=8, STAMP_W=64, DROP_W=16).
module tb_l2_mp_trace_buffer;

    logic         clock;
    logic         reset;
    logic         freeze;
    logic [63:0]  stamp;
    logic [1:0]   in_valid;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:0]   out_ch;
    logic [63:0]  out_data;
    logic [63:0]  out_stamp;
    logic [31:0]  drop_cnt;
    logic [7:0]   level;

    int tests;
    int fails;

    l2_mp_trace_buffer #(
        .NUM_CH  (2),
        .REC_W   (64),
        .DEPTH   (8),
        .STAMP_W (64),
        .DROP_W  (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .freeze    (freeze),
        .stamp     (stamp),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lvl(input int c);
        return 64'(level[c*4 +: 4]);
    endfunction

    function automatic logic [63:0] drp(input int c);
        return 64'(drop_cnt[c*16 +: 16]);
    endfunction

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        freeze    = 1'b0;
        stamp     = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_lvl0", lvl(0), 64'd0);
        check("rst_lvl1", lvl(1), 64'd0);
        check("rst_drop0", drp(0), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single push on ch0, visible one cycle later
        in_valid       = 2'b01;
        stamp          = 64'd100;
        in_data[63:0]  = 64'hA5A5_0000_0000_000A;
        check("t1_nobypass", 64'(out_valid), 64'd0);
        tick();
        in_valid = '0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_ch", 64'(out_ch), 64'd0);
        check("t1_data", out_data, 64'hA5A5_0000_0000_000A);
        check("t1_stamp", out_stamp, 64'd100);
        out_ready = 1'b1;
        tick();
        check("t1_drained", 64'(out_valid), 64'd0);

        // 2: both channels push for 6 cycles, drain alternates starting at ch1 (rr_ptr=1)
        in_valid        = 2'b11;
        in_data[63:0]   = 64'h100;
        in_data[127:64] = 64'h200;
        stamp           = 64'd200;
        tick();
        for (int j = 0; j < 12; j++) begin
            if (j + 1 < 6) begin
                in_data[63:0]   = 64'h100 + 64'(j + 1);
                in_data[127:64] = 64'h200 + 64'(j + 1);
                stamp           = 64'd200 + 64'(j + 1);
            end else begin
                in_valid = '0;
            end
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_ch", 64'(out_ch), (j % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_data", out_data,
                  ((j % 2 == 0) ? 64'h200 : 64'h100) + 64'(j / 2));
            check("t2_stamp", out_stamp, 64'd200 + 64'(j / 2));
            if (j == 5) begin
                check("t2_lvl0", lvl(0), 64'd4);
                check("t2_lvl1", lvl(1), 64'd3);
            end
            tick();
        end
        check("t2_empty", 64'(out_valid), 64'd0);
        check("t2_drop0", drp(0), 64'd0);
        check("t2_drop1", drp(1), 64'd0);

        // 3: ch0 overfilled by 3 with sink stalled
        out_ready = 1'b0;
        in_valid  = 2'b01;
        for (int k = 0; k < 11; k++) begin
            in_data[63:0] = 64'h300 + 64'(k);
            stamp         = 64'd300 + 64'(k);
            tick();
        end
        in_valid = '0;
        check("t3_lvl0", lvl(0), 64'd8);
        check("t3_drop0", drp(0), 64'd3);
        check("t3_lvl1", lvl(1), 64'd0);
        check("t3_ch", 64'(out_ch), 64'd0);
        check("t3_data", out_data, 64'h300);
        check("t3_stamp", out_stamp, 64'd300);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_drain", out_data, 64'h300 + 64'(k));
            tick();
        end
        check("t3_empty", 64'(out_valid), 64'd0);

        // 4: stalled ch1 grant stays locked while ch0 fills; next grant ch0
        out_ready       = 1'b0;
        in_valid        = 2'b10;
        in_data[127:64] = 64'h400;
        stamp           = 64'd400;
        tick();
        in_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            in_data[63:0] = 64'h500 + 64'(k);
            check("t4_lock_ch", 64'(out_ch), 64'd1);
            check("t4_lock_data", out_data, 64'h400);
            tick();
        end
        in_valid = '0;
        check("t4_held_ch", 64'(out_ch), 64'd1);
        check("t4_lvl0", lvl(0), 64'd4);
        out_ready = 1'b1;
        tick();
        check("t4_next_ch", 64'(out_ch), 64'd0);
        check("t4_next_data", out_data, 64'h500);

        // 5: full ch0 popping and pushing in the same cycle accepts the push
        out_ready = 1'b0;
        in_valid  = 2'b01;
        for (int k = 4; k < 8; k++) begin
            in_data[63:0] = 64'h500 + 64'(k);
            tick();
        end
        check("t5_full", lvl(0), 64'd8);
        check("t5_head", out_data, 64'h500);
        out_ready     = 1'b1;
        in_data[63:0] = 64'h508;
        tick();
        in_valid  = '0;
        out_ready = 1'b0;
        check("t5_lvl0", lvl(0), 64'd8);
        check("t5_drop0", drp(0), 64'd3);
        check("t5_head2", out_data, 64'h501);

        // 6: freeze ignores pushes but drain continues; then reset mid-drain
        freeze   = 1'b1;
        in_valid = 2'b11;
        tick();
        tick();
        check("t6_lvl0", lvl(0), 64'd8);
        check("t6_lvl1", lvl(1), 64'd0);
        check("t6_drop0", drp(0), 64'd3);
        check("t6_drop1", drp(1), 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_drain_lvl0", lvl(0), 64'd6);
        check("t6_drain_head", out_data, 64'h503);
        check("t6_drain_lvl1", lvl(1), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_lvl0", lvl(0), 64'd0);
        check("t6_rst_drop0", drp(0), 64'd0);
        tick();
        reset    = 1'b0;
        freeze   = 1'b0;
        in_valid = '0;
        tick();
        check("t6_post_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
